// File: rtl/umi_fifo_sync.sv
`default_nettype none
// ============================================================================
//  Module   : umi_fifo_sync
//  Purpose  : Single-clock UMI transaction FIFO with runtime bypass,
//             synchronous flush, occupancy count, programmable almost-full
//             threshold and LFSR-driven pseudo-random input pushback.
//  Ports    :
//    clk, nreset          clock / asynchronous active-low reset
//    bypass               combinational in->out passthrough, storage frozen
//    chaosmode            enable pseudo-random pushback on the input side
//    flush                synchronous clear of all stored entries
//    fifo_full/empty      occupancy == DEPTH / == 0
//    fifo_almost_full     occupancy >= AFULL
//    fifo_count           current occupancy
//    umi_in_*             input transaction (valid/ready handshake)
//    umi_out_*            output transaction (valid/ready handshake)
//    vdd, vss             supply pins, no logic function
//  Revision : 1.0  initial release
// ============================================================================
module umi_fifo_sync #(
    parameter int DEPTH = 4,
    parameter int AW    = 64,
    parameter int CW    = 32,
    parameter int DW    = 256,
    parameter int AFULL = DEPTH - 1
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     bypass,
    input  logic                     chaosmode,
    input  logic                     flush,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic                     fifo_almost_full,
    output logic [$clog2(DEPTH):0]   fifo_count,
    input  logic                     umi_in_valid,
    input  logic [CW-1:0]            umi_in_cmd,
    input  logic [AW-1:0]            umi_in_dstaddr,
    input  logic [AW-1:0]            umi_in_srcaddr,
    input  logic [DW-1:0]            umi_in_data,
    output logic                     umi_in_ready,
    output logic                     umi_out_valid,
    output logic [CW-1:0]            umi_out_cmd,
    output logic [AW-1:0]            umi_out_dstaddr,
    output logic [AW-1:0]            umi_out_srcaddr,
    output logic [DW-1:0]            umi_out_data,
    input  logic                     umi_out_ready,
    input  logic                     vdd,
    input  logic                     vss
);

    localparam int                c_iw    = $clog2(DEPTH);
    localparam int                c_pw    = c_iw + 1;
    localparam int                c_tw    = DW + AW + AW + CW;
    localparam logic [c_pw-1:0]   c_depth = c_pw'(DEPTH);
    localparam logic [c_pw-1:0]   c_afull = c_pw'(AFULL);
    localparam logic [15:0]       c_seed  = 16'hACE1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [c_pw-1:0] r_wr_ptr;
    logic [c_pw-1:0] r_rd_ptr;
    logic [15:0]     r_lfsr;
    logic [c_tw-1:0] r_mem [DEPTH];

    logic [c_pw-1:0] w_count;
    logic [c_tw-1:0] w_in_word;
    logic [c_tw-1:0] w_rd_word;
    logic            w_chaos_block;
    logic            w_push;
    logic            w_pop;
    logic            w_lfsr_fb;

    // Supplies are carried for netlist compatibility only.
    logic w_unused_supply;
    assign w_unused_supply = vdd ^ vss;

    // ------------------------------------------------------------------------
    // Status, derived purely from registered pointers
    // ------------------------------------------------------------------------
    assign w_count          = r_wr_ptr - r_rd_ptr;
    assign fifo_count       = w_count;
    assign fifo_empty       = (w_count == '0);
    assign fifo_full        = (w_count == c_depth);
    assign fifo_almost_full = (w_count >= c_afull);

    // ------------------------------------------------------------------------
    // Chaos pushback: free-running Fibonacci LFSR x^16+x^14+x^13+x^11+1
    // ------------------------------------------------------------------------
    assign w_lfsr_fb     = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_chaos_block = chaosmode & (r_lfsr[1:0] == 2'b00);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_lfsr <= c_seed;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    // ------------------------------------------------------------------------
    // Handshake and output selection
    // ------------------------------------------------------------------------
    // Word layout keeps cmd in the least significant bits.
    assign w_in_word = {umi_in_data, umi_in_srcaddr, umi_in_dstaddr, umi_in_cmd};
    assign w_rd_word = r_mem[r_rd_ptr[c_iw-1:0]];

    // Ready already excludes flush in fifo mode, so a flush cycle never pushes.
    assign umi_in_ready  = bypass ? umi_out_ready
                                  : (~fifo_full & ~w_chaos_block & ~flush);
    assign umi_out_valid = bypass ? umi_in_valid : ~fifo_empty;

    assign {umi_out_data, umi_out_srcaddr, umi_out_dstaddr, umi_out_cmd} =
        bypass ? w_in_word : w_rd_word;

    assign w_push = umi_in_valid  & umi_in_ready  & ~bypass;
    assign w_pop  = umi_out_valid & umi_out_ready & ~bypass;

    // ------------------------------------------------------------------------
    // Pointers: flush outranks any push or pop in the same cycle
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage is intentionally not reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_iw-1:0]] <= w_in_word;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_umi_fifo_sync.sv
`default_nettype none
// ============================================================================
//  Module   : tb_umi_fifo_sync
//  Purpose  : Self-checking bench for umi_fifo_sync. Directed stimulus, a
//             reference occupancy/LFSR model, and a scoreboard queue drained
//             by an independent output monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_umi_fifo_sync;

    localparam int DEPTH = 4;
    localparam int AW    = 64;
    localparam int CW    = 32;
    localparam int DW    = 256;
    localparam int AFULL = DEPTH - 1;
    localparam int TW    = DW + AW + AW + CW;
    localparam int PW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          nreset;
    logic          bypass;
    logic          chaosmode;
    logic          flush;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_almost_full;
    logic [PW-1:0] fifo_count;
    logic          umi_in_valid;
    logic [CW-1:0] umi_in_cmd;
    logic [AW-1:0] umi_in_dstaddr;
    logic [AW-1:0] umi_in_srcaddr;
    logic [DW-1:0] umi_in_data;
    logic          umi_in_ready;
    logic          umi_out_valid;
    logic [CW-1:0] umi_out_cmd;
    logic [AW-1:0] umi_out_dstaddr;
    logic [AW-1:0] umi_out_srcaddr;
    logic [DW-1:0] umi_out_data;
    logic          umi_out_ready;
    logic          vdd = 1'b1;
    logic          vss = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [TW-1:0] exp_q[$];
    logic [15:0]   m_lfsr;
    int            m_count;

    always #5 clk = ~clk;

    umi_fifo_sync #(
        .DEPTH(DEPTH), .AW(AW), .CW(CW), .DW(DW), .AFULL(AFULL)
    ) u_dut (
        .clk              (clk),
        .nreset           (nreset),
        .bypass           (bypass),
        .chaosmode        (chaosmode),
        .flush            (flush),
        .fifo_full        (fifo_full),
        .fifo_empty       (fifo_empty),
        .fifo_almost_full (fifo_almost_full),
        .fifo_count       (fifo_count),
        .umi_in_valid     (umi_in_valid),
        .umi_in_cmd       (umi_in_cmd),
        .umi_in_dstaddr   (umi_in_dstaddr),
        .umi_in_srcaddr   (umi_in_srcaddr),
        .umi_in_data      (umi_in_data),
        .umi_in_ready     (umi_in_ready),
        .umi_out_valid    (umi_out_valid),
        .umi_out_cmd      (umi_out_cmd),
        .umi_out_dstaddr  (umi_out_dstaddr),
        .umi_out_srcaddr  (umi_out_srcaddr),
        .umi_out_data     (umi_out_data),
        .umi_out_ready    (umi_out_ready),
        .vdd              (vdd),
        .vss              (vss)
    );

    task automatic chk(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Distinct, tag-derived contents for every field.
    function automatic logic [TW-1:0] pack(input int tag);
        logic [31:0] t;
        t = tag;
        pack = {{8{t ^ 32'h1234_5678}}, {t, 32'h5A5A_5A5A}, {32'hDD00_0000 ^ t, t}, t};
    endfunction

    function automatic logic [TW-1:0] in_word();
        return {umi_in_data, umi_in_srcaddr, umi_in_dstaddr, umi_in_cmd};
    endfunction

    function automatic logic [TW-1:0] out_word();
        return {umi_out_data, umi_out_srcaddr, umi_out_dstaddr, umi_out_cmd};
    endfunction

    function automatic logic m_ready();
        if (bypass) return umi_out_ready;
        return (m_count != DEPTH) && !(chaosmode && (m_lfsr[1:0] == 2'b00)) && !flush;
    endfunction

    // ------------------------------------------------------------------------
    // Reference model: occupancy, LFSR, and expected-transaction queue
    // ------------------------------------------------------------------------
    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            m_lfsr  <= 16'hACE1;
            m_count <= 0;
            exp_q.delete();
        end else begin
            logic mpush, mpop;
            mpush = umi_in_valid && m_ready() && !bypass && !flush;
            mpop  = (m_count != 0) && umi_out_ready && !bypass && !flush;
            if (flush) begin
                m_count <= 0;
                exp_q.delete();
            end else begin
                m_count <= m_count + int'(mpush) - int'(mpop);
                if (mpush) exp_q.push_back(in_word());
            end
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    // Per-cycle status / handshake comparison against the model.
    always @(negedge clk) begin
        chk("in_ready", umi_in_ready, m_ready());
        if (bypass) begin
            chk("byp_valid", umi_out_valid, umi_in_valid);
            chk("byp_word", out_word(), in_word());
        end else begin
            chk("out_valid", umi_out_valid, m_count != 0);
        end
        chk("count", fifo_count, m_count);
        chk("empty", fifo_empty, m_count == 0);
        chk("full", fifo_full, m_count == DEPTH);
        chk("afull", fifo_almost_full, m_count >= AFULL);
    end

    // Output monitor: every accepted output must match the scoreboard head.
    always @(negedge clk) begin
        if (nreset && !bypass && !flush && umi_out_valid && umi_out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mon_underflow: got output %0h expected none at %0t", out_word(), $time);
            end else begin
                chk("mon_txn", out_word(), exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic v, input int tag, input logic ordy);
        umi_in_valid  = v;
        {umi_in_data, umi_in_srcaddr, umi_in_dstaddr, umi_in_cmd} = pack(tag);
        umi_out_ready = ordy;
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  t;
        logic acc;
        nreset    = 1'b0;
        bypass    = 1'b0;
        chaosmode = 1'b0;
        flush     = 1'b0;
        drive(1'b0, 0, 1'b0);
        step(3);

        // Reset state
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_afull", fifo_almost_full, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_valid", umi_out_valid, 0);
        chk("rst_ready", umi_in_ready, 1);
        nreset = 1'b1;
        step();

        // Fill A..D with output stalled, then drain in order
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'hA0 + k, 1'b0);
            step();
            chk("fill_count", fifo_count, k + 1);
            chk("fill_afull", fifo_almost_full, (k + 1) >= 3);
            chk("fill_full", fifo_full, (k + 1) == 4);
        end
        chk("full_ready", umi_in_ready, 0);
        drive(1'b0, 0, 1'b1);
        step(4);
        chk("drain_empty", fifo_empty, 1);

        // Streaming: one transaction per cycle
        t = 100;
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, t, 1'b1);
            step();
            chk("stream_le1", fifo_count <= 1, 1);
            t++;
        end
        drive(1'b0, 0, 1'b1);
        step(2);

        // Full with simultaneous pop, then push+pop past pointer wrap
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'hB0 + k, 1'b0);
            step();
        end
        drive(1'b1, 32'hC0, 1'b1);
        step();
        chk("fullpop_count", fifo_count, 3);
        step();
        chk("pushpop_count", fifo_count, 3);
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 32'hC0 + k, 1'b1);
            step();
            chk("wrap_count", fifo_count, 3);
        end
        drive(1'b0, 0, 1'b1);
        step(4);
        chk("wrap_empty", fifo_empty, 1);

        // Flush with 3 entries and a valid input in the flush cycle
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'hD0 + k, 1'b0);
            step();
        end
        drive(1'b1, 32'hDF, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 0, 1'b1);
        chk("flush_count", fifo_count, 0);
        chk("flush_empty", fifo_empty, 1);
        step(2);
        chk("flush_novalid", umi_out_valid, 0);

        // Bypass with 2 entries held
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'hE0 + k, 1'b0);
            step();
        end
        bypass = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive(k[0], 32'hF0 + k, ~k[1]);
            #1;
            chk("byp_comb", out_word(), pack(32'hF0 + k));
            step();
            chk("byp_count", fifo_count, 2);
        end
        bypass = 1'b0;
        drive(1'b0, 0, 1'b1);
        step(3);
        chk("byp_drain_empty", fifo_empty, 1);

        // Chaos pushback: ready must follow the LFSR model exactly
        chaosmode = 1'b1;
        t = 1000;
        for (int k = 0; k < 1000; k++) begin
            drive(1'b1, t, 1'b1);
            @(negedge clk);
            acc = umi_in_ready;
            @(posedge clk);
            #1;
            if (acc) t++;
        end
        chaosmode = 1'b0;
        drive(1'b0, 0, 1'b1);
        step(4);

        // Reset asserted with entries stored
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'h77 + k, 1'b0);
            step();
        end
        drive(1'b0, 0, 1'b1);
        #3;
        nreset = 1'b0;
        #1;
        chk("midrst_valid", umi_out_valid, 0);
        chk("midrst_count", fifo_count, 0);
        chk("midrst_empty", fifo_empty, 1);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        step(2);
        chk("postrst_valid", umi_out_valid, 0);

        chk("final_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
